// File: rtl/lcd_arbitro.sv
// lcd_arbitro: round-robin arbiter sharing the LCD timing engine between two byte requesters.
// Define LCD_PAUSA_LARGA_EN to add the WAIT_CYC pause after clear (8'h01) / home (8'h02) commands.
module lcd_arbitro #(
   parameter int WAIT_CYC = 82000
) (
   input  logic       CLK,
   input  logic       RST,
   input  logic       INILISTA,
   input  logic       REQ0,
   input  logic       REQ1,
   input  logic [7:0] BYTE0,
   input  logic [7:0] BYTE1,
   input  logic       RS0,
   input  logic       RS1,
   input  logic       TM,
   output logic       INITM,
   output logic [7:0] BYTESAL,
   output logic       LCD_RS,
   output logic       GNT0,
   output logic       GNT1,
   output logic       ACK0,
   output logic       ACK1,
   output logic       BUSY
);
   typedef enum logic [1:0] {ESPERA_INI, LIBRE, ENVIA, PAUSA} estado_t;
   estado_t estado, estado_n;
   logic ult, ult_n, r0, r1, concede, sel, fin, larga, cero;
   logic initm_n, rs_n, g0_n, g1_n, a0_n, a1_n, busy_n;
   logic [7:0] byte_n;
   if (WAIT_CYC < 1 || WAIT_CYC > 131071) begin : g_wait_cyc_fuera_de_rango
   end
   // a requester being acknowledged this cycle is masked so the other one gets the next slot
   assign r0      = REQ0 & ~ACK0;
   assign r1      = REQ1 & ~ACK1;
   assign concede = (estado == LIBRE) && (r0 || r1);
   assign sel     = (r0 && r1) ? ~ult : r1;
   assign fin     = (estado == ENVIA) && TM;
`ifdef LCD_PAUSA_LARGA_EN
   logic [16:0] cnt;
   assign larga = ~LCD_RS && (BYTESAL == 8'h01 || BYTESAL == 8'h02);
   assign cero  = cnt == '0;
   always_ff @(posedge CLK)
      if (RST) cnt <= '0;
      else cnt <= (fin && larga) ? 17'(WAIT_CYC - 1) : cero ? cnt : cnt - 17'd1;
`else
   assign larga = 1'b0;
   assign cero  = 1'b1;
`endif
   always_ff @(posedge CLK)
      if (RST) begin
         estado  <= ESPERA_INI;
         ult     <= 1'b1;
         INITM   <= 1'b0;
         BYTESAL <= 8'h00;
         LCD_RS  <= 1'b0;
         GNT0    <= 1'b0;
         GNT1    <= 1'b0;
         ACK0    <= 1'b0;
         ACK1    <= 1'b0;
         BUSY    <= 1'b1;
      end else begin
         estado  <= estado_n;
         ult     <= ult_n;
         INITM   <= initm_n;
         BYTESAL <= byte_n;
         LCD_RS  <= rs_n;
         GNT0    <= g0_n;
         GNT1    <= g1_n;
         ACK0    <= a0_n;
         ACK1    <= a1_n;
         BUSY    <= busy_n;
      end
   always_comb begin
      estado_n = estado;
      case (estado)
         ESPERA_INI: estado_n = INILISTA ? LIBRE : ESPERA_INI;
         LIBRE:      estado_n = concede ? ENVIA : LIBRE;
         ENVIA:      estado_n = !TM ? ENVIA : larga ? PAUSA : LIBRE;
         default:    estado_n = cero ? LIBRE : PAUSA;
      endcase
   end
   always_comb begin
      initm_n = estado_n == ENVIA;
      g0_n    = concede ? ~sel : GNT0 & initm_n;
      g1_n    = concede ? sel : GNT1 & initm_n;
      a0_n    = fin & GNT0;
      a1_n    = fin & GNT1;
      busy_n  = estado_n != LIBRE;
      byte_n  = concede ? (sel ? BYTE1 : BYTE0) : BYTESAL;
      rs_n    = concede ? (sel ? RS1 : RS0) : LCD_RS;
      ult_n   = concede ? sel : ult;
   end
endmodule

// File: tb/tb_lcd_arbitro.sv
// tb_lcd_arbitro: directed stimulus with a grant scoreboard for lcd_arbitro.
// Expected grants {requester, rs, byte} are queued by the stimulus and popped by the monitor.
module tb_lcd_arbitro;
   localparam int WAIT = 10;
`ifdef LCD_PAUSA_LARGA_EN
   localparam int PAUSA_EXP = WAIT;
`else
   localparam int PAUSA_EXP = 0;
`endif
   logic CLK = 0, RST = 1, INILISTA = 0, REQ0 = 0, REQ1 = 0, RS0 = 0, RS1 = 0, TM = 0;
   logic [7:0] BYTE0 = 0, BYTE1 = 0;
   logic INITM, LCD_RS, GNT0, GNT1, ACK0, ACK1, BUSY;
   logic [7:0] BYTESAL;
   int n_chk = 0, n_fail = 0;
   logic [9:0] exp_q[$];
   logic [9:0] exp_e;
   logic last_who = 0, prev_initm = 0;

   always #5 CLK = ~CLK;

   lcd_arbitro #(.WAIT_CYC(WAIT)) dut (
      .CLK(CLK), .RST(RST), .INILISTA(INILISTA),
      .REQ0(REQ0), .REQ1(REQ1), .BYTE0(BYTE0), .BYTE1(BYTE1), .RS0(RS0), .RS1(RS1),
      .TM(TM), .INITM(INITM), .BYTESAL(BYTESAL), .LCD_RS(LCD_RS),
      .GNT0(GNT0), .GNT1(GNT1), .ACK0(ACK0), .ACK1(ACK1), .BUSY(BUSY)
   );

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, got, exp);
      end
   endtask

   // monitor: every new grant is compared against the scoreboard head
   always @(negedge CLK) begin
      if (INITM && !prev_initm) begin
         if (exp_q.size() == 0) chk("unexpected_grant", 1, 0);
         else begin
            exp_e = exp_q.pop_front();
            chk("grant_who", GNT1, exp_e[9]);
            chk("grant_onehot", GNT0 ^ GNT1, 1);
            chk("grant_rs", LCD_RS, exp_e[8]);
            chk("grant_byte", BYTESAL, exp_e[7:0]);
            last_who = GNT1;
         end
      end
      if (ACK0 || ACK1) begin
         chk("ack_owner", ACK1, last_who);
         chk("ack_onehot", ACK0 & ACK1, 0);
      end
      prev_initm = INITM;
   end

   task automatic tick(input int n = 1);
      repeat (n) @(posedge CLK);
      #1;
   endtask

   task automatic pulse_tm();
      TM = 1;
      tick();
      TM = 0;
   endtask

   task automatic wait_gnt(input logic who);
      int i = 0;
      while (!(who ? GNT1 : GNT0) && i < 50) begin
         tick();
         i++;
      end
      chk("grant_timeout", who ? GNT1 : GNT0, 1);
   endtask

   task automatic check_reset(input string tag);
      chk({tag, "_initm"}, INITM, 0);
      chk({tag, "_bytesal"}, BYTESAL, 0);
      chk({tag, "_lcd_rs"}, LCD_RS, 0);
      chk({tag, "_gnt"}, {GNT0, GNT1}, 0);
      chk({tag, "_ack"}, {ACK0, ACK1}, 0);
      chk({tag, "_busy"}, BUSY, 1);
   endtask

   // one byte with no pause expected; starts in an idle LIBRE cycle
   task automatic send(input logic who, input logic [7:0] b, input logic rs);
      exp_q.push_back({who, rs, b});
      if (who) begin REQ1 = 1; BYTE1 = b; RS1 = rs; end
      else begin REQ0 = 1; BYTE0 = b; RS0 = rs; end
      tick();
      chk("grant_latency", who ? GNT1 : GNT0, 1);
      chk("grant_initm", INITM, 1);
      REQ0 = 0;
      REQ1 = 0;
      tick(2);
      pulse_tm();
      chk("ack", who ? ACK1 : ACK0, 1);
      chk("ack_initm", INITM, 0);
      chk("ack_gnt", {GNT0, GNT1}, 0);
      chk("ack_busy", BUSY, 0);
      tick();
      chk("ack_pulse", {ACK0, ACK1}, 0);
   endtask

   initial begin
      logic bad;
      int n;
      tick(2);
      check_reset("rst");
      RST = 0;
      REQ0 = 1;
      BYTE0 = 8'hA5;
      bad = 0;
      repeat (50) begin
         tick();
         if (GNT0 || GNT1 || !BUSY) bad = 1;
      end
      chk("no_grant_before_init", bad, 0);
      exp_q.push_back({1'b0, 1'b0, 8'hA5});
      INILISTA = 1;
      tick();
      INILISTA = 0;
      chk("libre_busy", BUSY, 0);
      chk("libre_no_gnt", GNT0, 0);
      tick();
      chk("init_gnt0", GNT0, 1);
      chk("init_initm", INITM, 1);
      chk("init_bytesal", BYTESAL, 8'hA5);
      REQ0 = 0;
      BYTE0 = 8'hFF;
      tick(3);
      chk("envia_hold_byte", BYTESAL, 8'hA5);
      chk("envia_hold_gnt", GNT0, 1);
      pulse_tm();
      chk("ack0", ACK0, 1);
      chk("ack0_initm", INITM, 0);
      chk("ack0_busy", BUSY, 0);
      tick();
      chk("ack0_pulse", ACK0, 0);
      chk("idle_keeps_byte", BYTESAL, 8'hA5);
      pulse_tm();
      chk("tm_idle_ignored", {ACK0, ACK1, INITM}, 0);
      tick();
      send(0, 8'h52, 1);
      send(1, 8'h33, 0);
      // both requesters held: strict alternation starting with requester 0
      BYTE0 = 8'h10; BYTE1 = 8'h20; RS0 = 1; RS1 = 1;
      for (int k = 0; k < 6; k++) exp_q.push_back({k[0], 1'b1, k[0] ? 8'h20 : 8'h10});
      REQ0 = 1;
      REQ1 = 1;
      for (int k = 0; k < 6; k++) begin
         wait_gnt(k[0]);
         if (k == 5) begin REQ0 = 0; REQ1 = 0; end
         pulse_tm();
         chk("rr_ack", k[0] ? ACK1 : ACK0, 1);
         chk("rr_gap", INITM, 0);
      end
      tick();
      chk("rr_idle", {GNT0, GNT1}, 0);
      chk("rr_drained", exp_q.size(), 0);
      // reset in the middle of a transfer
      exp_q.push_back({1'b0, 1'b0, 8'h77});
      REQ0 = 1; BYTE0 = 8'h77; RS0 = 0;
      tick();
      chk("abort_gnt", GNT0, 1);
      REQ0 = 0;
      tick();
      RST = 1;
      tick();
      RST = 0;
      check_reset("abort");
      pulse_tm();
      chk("abort_tm_no_ack", {ACK0, ACK1}, 0);
      tick(3);
      chk("abort_still_waiting", {BUSY, GNT0, GNT1}, 3'b100);
      INILISTA = 1;
      tick();
      INILISTA = 0;
      send(0, 8'h02, 1);
      // clear command followed by a pending requester 1
      exp_q.push_back({1'b0, 1'b0, 8'h01});
      exp_q.push_back({1'b1, 1'b1, 8'h44});
      REQ0 = 1; BYTE0 = 8'h01; RS0 = 0;
      tick();
      chk("clr_gnt", GNT0, 1);
      REQ0 = 0; REQ1 = 1; BYTE1 = 8'h44; RS1 = 1;
      tick(2);
      chk("envia_ignores_req1", GNT1, 0);
      pulse_tm();
      chk("clr_ack", ACK0, 1);
      n = 0;
      while (BUSY && !GNT1 && n < 100) begin
         n++;
         tick();
      end
      chk("pause_busy_cycles", n, PAUSA_EXP);
      chk("pause_libre_gap", GNT1, 0);
      tick();
      chk("post_pause_gnt1", GNT1, 1);
      REQ1 = 0;
      pulse_tm();
      chk("post_pause_ack1", ACK1, 1);
      tick();
      send(0, 8'h01, 1);
      chk("final_drained", exp_q.size(), 0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
